// File: rtl/onehot_rr_arbiter.sv
// Round-robin arbiter feeding the 8-to-3 encoder: latches request pulses and
// hands out exactly one pending line at a time as a one-hot grant with valid/ready.
module onehot_rr_arbiter #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         ready,
    input  logic         clr_ovf,
    output logic [N-1:0] grant,
    output logic         valid,
    output logic [N-1:0] pending,
    output logic         ovf
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [N-1:0]   pending_q, pending_d;
    logic [N-1:0]   grant_q, grant_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  gidx_q, gidx_d;

    logic [N-1:0]   clr_mask;
    logic           found;
    logic [PW-1:0]  sel;
    logic [PW-1:0]  idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            ovf_q     <= 1'b0;
            ptr_q     <= '0;
            gidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            ovf_q     <= ovf_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
        end
    end

    // A line being accepted this cycle is cleared, unless it re-requests at the same time.
    always_comb begin
        clr_mask  = (state_q == GRANT && ready) ? grant_q : '0;
        pending_d = (pending_q & ~clr_mask) | req;
        if (|(req & pending_q & ~clr_mask)) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Search starts at ptr and wraps; only registered pending is considered.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = ptr_q + PW'(i);
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        valid_d = valid_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = {{(N-1){1'b0}}, 1'b1} << sel;
                    valid_d = 1'b1;
                    gidx_d  = sel;
                    state_d = GRANT;
                end else begin
                    grant_d = '0;
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (ready) begin
                    ptr_d   = gidx_q + PW'(1);
                    grant_d = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                grant_d = '0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign grant   = grant_q;
    assign valid   = valid_q;
    assign pending = pending_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Scoreboard bench for onehot_rr_arbiter: directed request patterns push expected
// grants; a negedge monitor pops one entry per accepted grant and compares.
module tb_onehot_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       ready;
    logic       clr_ovf;
    logic [7:0] grant;
    logic       valid;
    logic [7:0] pending;
    logic       ovf;

    int nCompared   = 0;
    int nMismatched = 0;
    logic [7:0] expQ[$];

    onehot_rr_arbiter #(.N(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .ready   (ready),
        .clr_ovf (clr_ovf),
        .grant   (grant),
        .valid   (valid),
        .pending (pending),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // Monitor: a transfer happens on the next rising edge when valid and ready are both high.
    always @(negedge clk) begin
        if (!rst) begin
            nCompared++;
            if ((valid && !$onehot(grant)) || (!valid && grant != 8'h00)) begin
                nMismatched++;
                $display("[TB] FAIL grant_shape: valid=%0b grant=%h, required one-hot when valid, zero otherwise", valid, grant);
            end
            if (valid && ready) begin
                nCompared++;
                if (expQ.size() == 0) begin
                    nMismatched++;
                    $display("[TB] FAIL unexpected_grant: got grant=%h, required no grant", grant);
                end else begin
                    logic [7:0] e;
                    e = expQ.pop_front();
                    if (grant !== e) begin
                        nMismatched++;
                        $display("[TB] FAIL grant_order: got %h, required %h", grant, e);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] r, input logic rdy, input logic clr);
        req     = r;
        ready   = rdy;
        clr_ovf = clr;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
    endtask

    task automatic waitDrain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (expQ.size() == 0) break;
            tick();
        end
        tick();
        nCompared++;
        if (expQ.size() != 0) begin
            nMismatched++;
            $display("[TB] FAIL %s: %0d grants outstanding, required 0", name, expQ.size());
            expQ.delete();
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(8'h00, 1'b0, 1'b0);
        #2;
        checkOutput("rst_grant",   grant,          8'h00);
        checkOutput("rst_valid",   {7'b0, valid},  8'h00);
        checkOutput("rst_pending", pending,        8'h00);
        checkOutput("rst_ovf",     {7'b0, ovf},    8'h00);
        tick();
        rst = 1'b0;

        // Single request: two-cycle latency then one bubble.
        applyStimulus(8'h08, 1'b1, 1'b0);
        expQ.push_back(8'h08);
        tick();
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("lat_pending", pending,       8'h08);
        checkOutput("lat_valid0",  {7'b0, valid}, 8'h00);
        tick();
        checkOutput("lat_valid1",  {7'b0, valid}, 8'h01);
        checkOutput("lat_grant",   grant,         8'h08);
        tick();
        checkOutput("lat_valid2",  {7'b0, valid}, 8'h00);
        checkOutput("lat_drained", pending,       8'h00);

        // All lines at once: served 0..7 in order.
        doReset();
        applyStimulus(8'hFF, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] g;
            g = 8'h01 << i;
            expQ.push_back(g);
        end
        tick();
        applyStimulus(8'h00, 1'b1, 1'b0);
        waitDrain("all_drain", 40);
        checkOutput("all_pending", pending, 8'h00);

        // Wrap-around from ptr 7.
        doReset();
        applyStimulus(8'h40, 1'b1, 1'b0);
        expQ.push_back(8'h40);
        tick();
        applyStimulus(8'h00, 1'b1, 1'b0);
        waitDrain("wrap_first", 10);
        applyStimulus(8'h81, 1'b1, 1'b0);
        expQ.push_back(8'h80);
        expQ.push_back(8'h01);
        tick();
        applyStimulus(8'h00, 1'b1, 1'b0);
        waitDrain("wrap_drain", 20);

        // Backpressure: grant must hold while ready is low.
        doReset();
        applyStimulus(8'h05, 1'b0, 1'b0);
        expQ.push_back(8'h01);
        expQ.push_back(8'h02);
        expQ.push_back(8'h04);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 10; i++) begin
            applyStimulus((i % 2 == 0) ? 8'h02 : 8'h00, 1'b0, 1'b0);
            tick();
            checkOutput("bp_grant", grant,         8'h01);
            checkOutput("bp_valid", {7'b0, valid}, 8'h01);
        end
        applyStimulus(8'h00, 1'b1, 1'b0);
        waitDrain("bp_drain", 30);
        checkOutput("bp_pending", pending, 8'h00);

        // Overflow: second request on a pending line sets the sticky flag, one grant only.
        doReset();
        applyStimulus(8'h08, 1'b0, 1'b0);
        expQ.push_back(8'h08);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("ovf_before", {7'b0, ovf}, 8'h00);
        applyStimulus(8'h08, 1'b0, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("ovf_set", {7'b0, ovf}, 8'h01);
        applyStimulus(8'h00, 1'b1, 1'b0);
        waitDrain("ovf_drain", 10);
        repeat (4) tick();
        checkOutput("ovf_single", pending,     8'h00);
        checkOutput("ovf_sticky", {7'b0, ovf}, 8'h01);
        applyStimulus(8'h00, 1'b1, 1'b1);
        tick();
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("ovf_clear", {7'b0, ovf}, 8'h00);

        // Accept and re-request on the same line: stays pending, no overflow, served after others.
        doReset();
        applyStimulus(8'h03, 1'b0, 1'b0);
        expQ.push_back(8'h01);
        expQ.push_back(8'h02);
        expQ.push_back(8'h01);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        applyStimulus(8'h01, 1'b1, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("rereq_pending", pending,     8'h03);
        checkOutput("rereq_ovf",     {7'b0, ovf}, 8'h00);
        waitDrain("rereq_drain", 20);

        // Reset mid-grant clears everything immediately.
        doReset();
        applyStimulus(8'h30, 1'b0, 1'b0);
        tick();
        applyStimulus(8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("mid_valid_pre", {7'b0, valid}, 8'h01);
        checkOutput("mid_grant_pre", grant,         8'h10);
        rst = 1'b1;
        #1;
        checkOutput("mid_valid", {7'b0, valid}, 8'h00);
        checkOutput("mid_grant", grant,         8'h00);
        checkOutput("mid_pend",  pending,       8'h00);
        tick();
        rst = 1'b0;
        applyStimulus(8'h00, 1'b1, 1'b0);
        repeat (6) tick();
        checkOutput("mid_quiet", {7'b0, valid}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
